decode_stage_pl: RTL and testbench
==================================

// Module: decode_stage_pl
// PURPOSE
//  Pipelined, parametrised decode stage. Holds the architectural register file, extends immediates,
//  resolves branches/jumps in decode and drives the ID/EX pipeline register through a valid/ready
//  handshake. Sits between fetch (in_*) and execute (out_*) and adds load-use/branch-operand stalls
//  and one-slot redirect flush.
// PARAMETERS
//  W      16  datapath and instruction width
//  NREG   8   register count; RA = $clog2(NREG) register-address width (instr fields stay 3 bits wide)
// PORTS
//  clk          in   1    clock, all state on rising edge
//  rst          in   1    asynchronous, active-low reset
//  in_valid     in   1    fetch presents instr/pc
//  in_ready     out  1    decode accepts instr this cycle
//  instr        in   W    instruction word
//  pc           in   W    address of next sequential instr (fetch_addr)
//  ctl          in   12   {reg_write,mem_read,reg2_rd_sel,im_sel,sign_ext,rd_sel[1:0],brj_sel,br_en,br_op[1:0],stu_sel}
//  wb_en        in   1    writeback enable
//  wb_reg       in   RA   writeback register
//  wb_data      in   W    writeback data
//  ex_ready     in   1    execute accepts ID/EX contents
//  out_valid    out  1    ID/EX register holds a live instr
//  out_data1    out  W    rs value; out_data2 out W rt/rd value; out_imm out W extended immediate
//  out_wreg     out  RA   destination; out_we out 1; out_mem_read out 1
//  redirect     out  1    one-cycle pulse: taken branch/jump
//  redirect_pc  out  W    pc + offset, held with redirect
// BEHAVIOUR
//  - Reset (rst=0, async): regfile all 0; out_valid=0; all out_* = 0; redirect=0; redirect_pc=0.
//  - Fields: rs=instr[10:8]; rt2 = reg2_rd_sel ? rd : instr[7:5]; rd per rd_sel: 00 instr[4:2],
//    01 instr[7:5], 10 instr[10:8], 11 NREG-1; if stu_sel, wreg=instr[10:8].
//  - Imm: im_sel ? ext8(instr[7:0]) : ext5(instr[4:0]), sign_ext selects sign/zero. Jump offset
//    = sext11(instr[10:0]) always signed.
//  - Regfile: write at posedge when wb_en. Reads combinational; same-cycle wb_reg match forwards
//    wb_data (write-before-read).
//  - Hazard (hz), combinational: out_valid & out_we & out_wreg in {rs, rt2 used} & (out_mem_read |
//    br_en). Such a branch also needs its rs operand; brj_sel jumps never raise hz.
//  - in_ready = (!out_valid | ex_ready) & !hz, or 1 while squashing.
//  - Accept (in_valid & in_ready & !squash): ID/EX loads next cycle, out_valid=1.
//  - Bubble: hz & ex_ready: out_valid<=0. Hold: out_valid & !ex_ready: out_* unchanged.
//  - Branch: rs value v. br_op 00 v==0, 01 v!=0, 10 v<0 signed, 11 v>=0.
//    taken = brj_sel | (br_en & cond).
//    target = pc + (brj_sel ? joff : imm); 16-bit wrap, no overflow flag.
//  - On accepted taken: redirect=1, redirect_pc=target, both registered (1-cycle latency). The
//    branch itself still enters ID/EX (link write for rd_sel=11).
//  - Squash: the cycle redirect=1, any in_valid is dropped, not decoded, and in_ready=1.
//    Redirect deasserts after 1 cycle.
//  - Simultaneous wb_en and stall: write always lands, and the stalled instr rereads next cycle.
//  - rst asserted mid-stall or mid-redirect: all clears immediately, and no pending redirect
//    survives.
// CONFIGURATION
//  DECODE_PERF_CNT_EN: defined -> adds outputs stall_cnt[15:0] (cycles with in_valid & hz) and
//  flush_cnt[15:0] (squashed in_valid beats). Both are saturating at 16'hFFFF and reset to 0.
//  Undefined -> ports and counters are absent, and all other behaviour is identical.
// TESTING
//  1 reset: rst=0 mid-traffic -> out_valid=0, redirect=0; regs read 0 after release.
//  2 wb R3=16'h1234, same cycle decode rs=R3 -> out_data1=16'h1234 next cycle.
//  3 load R2 in ID/EX (mem_read), next instr rt=R2 -> in_ready=0 one cycle, bubble (out_valid=0),
//    then issue.
//  4 beqz rs=R1=0, imm8=8'hFC, pc=16'h0010 -> redirect=1, redirect_pc=16'h000C for 1 cycle; the
//    following in_valid beat is squashed.
//  5 jump instr[10:0]=11'h400, pc=16'h0002 -> redirect_pc=16'hFC02; bltz with R1=16'h8000 taken,
//    bgez not taken.
//  6 ex_ready=0 for 3 cycles -> out_* stable, in_ready=0; with DECODE_PERF_CNT_EN, 3 hazard
//    cycles -> stall_cnt=3.

Source files
------------

// File: rtl/decode_stage_pl.sv
// decode_stage_pl: register file, immediate extension, decode-time branch resolution and ID/EX register.
// Optional DECODE_PERF_CNT_EN adds saturating stall/flush counters.
module decode_stage_pl #(
    parameter int W    = 16,
    parameter int NREG = 8,
    localparam int RA  = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [W-1:0]  instr_i,
    input  logic [W-1:0]  pc_i,
    input  logic [11:0]   ctl_i,
    input  logic          wb_en_i,
    input  logic [RA-1:0] wb_reg_i,
    input  logic [W-1:0]  wb_data_i,
    input  logic          ex_ready_i,
    output logic          out_valid_o,
    output logic [W-1:0]  out_data1_o,
    output logic [W-1:0]  out_data2_o,
    output logic [W-1:0]  out_imm_o,
    output logic [RA-1:0] out_wreg_o,
    output logic          out_we_o,
    output logic          out_mem_read_o,
    output logic          redirect_o,
    output logic [W-1:0]  redirect_pc_o
`ifdef DECODE_PERF_CNT_EN
    ,
    output logic [15:0]   stall_cnt_o,
    output logic [15:0]   flush_cnt_o
`endif
);
    logic [W-1:0] rf_q [NREG];
    logic reg_write, mem_read, reg2_sel, im_sel, sign_ext, brj_sel, br_en, stu_sel;
    logic [1:0] rd_sel, br_op;
    logic [RA-1:0] rs, rd, rt2, wreg;
    logic [W-1:0] v1, v2, imm, joff, target;
    logic cond, taken, hz, squash, accept;
    logic          out_valid_q, out_we_q, out_mem_read_q, redirect_q;
    logic [W-1:0]  out_data1_q, out_data2_q, out_imm_q, redirect_pc_q;
    logic [RA-1:0] out_wreg_q;
    logic unused_hi;

    assign unused_hi = ^instr_i[W-1:11];
    assign {reg_write, mem_read, reg2_sel, im_sel, sign_ext, rd_sel, brj_sel, br_en, br_op, stu_sel} = ctl_i;

    assign rs   = RA'(instr_i[10:8]);
    assign rd   = rd_sel == 2'b00 ? RA'(instr_i[4:2]) :
                  rd_sel == 2'b01 ? RA'(instr_i[7:5]) :
                  rd_sel == 2'b10 ? rs : RA'(NREG - 1);
    assign rt2  = reg2_sel ? rd : RA'(instr_i[7:5]);
    assign wreg = stu_sel ? rs : rd;

    // Write-before-read: a same-cycle writeback is visible to decode.
    assign v1 = (wb_en_i && wb_reg_i == rs)  ? wb_data_i : rf_q[rs];
    assign v2 = (wb_en_i && wb_reg_i == rt2) ? wb_data_i : rf_q[rt2];

    assign imm  = im_sel ? {{(W-8){sign_ext & instr_i[7]}}, instr_i[7:0]}
                         : {{(W-5){sign_ext & instr_i[4]}}, instr_i[4:0]};
    assign joff = {{(W-11){instr_i[10]}}, instr_i[10:0]};

    assign cond   = br_op == 2'b00 ? v1 == '0 :
                    br_op == 2'b01 ? v1 != '0 :
                    br_op == 2'b10 ? v1[W-1] : !v1[W-1];
    assign taken  = brj_sel | (br_en & cond);
    assign target = pc_i + (brj_sel ? joff : imm);

    // Loads are not forwardable; branches resolve here so any pending write blocks them.
    assign hz = out_valid_q & out_we_q & !brj_sel & (out_wreg_q == rs | out_wreg_q == rt2) &
                (out_mem_read_q | br_en);

    assign squash     = redirect_q;
    assign in_ready_o = squash | ((!out_valid_q | ex_ready_i) & !hz);
    assign accept     = in_valid_i & in_ready_o & !squash;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else if (wb_en_i) begin
            rf_q[wb_reg_i] <= wb_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q    <= 1'b0;
            out_data1_q    <= '0;
            out_data2_q    <= '0;
            out_imm_q      <= '0;
            out_wreg_q     <= '0;
            out_we_q       <= 1'b0;
            out_mem_read_q <= 1'b0;
            redirect_q     <= 1'b0;
            redirect_pc_q  <= '0;
        end else begin
            redirect_q <= accept & taken;
            if (accept & taken) redirect_pc_q <= target;
            if (accept) begin
                out_valid_q    <= 1'b1;
                out_data1_q    <= v1;
                out_data2_q    <= v2;
                out_imm_q      <= imm;
                out_wreg_q     <= wreg;
                out_we_q       <= reg_write;
                out_mem_read_q <= mem_read;
            end else if (ex_ready_i | !out_valid_q) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid_o    = out_valid_q;
    assign out_data1_o    = out_data1_q;
    assign out_data2_o    = out_data2_q;
    assign out_imm_o      = out_imm_q;
    assign out_wreg_o     = out_wreg_q;
    assign out_we_o       = out_we_q;
    assign out_mem_read_o = out_mem_read_q;
    assign redirect_o     = redirect_q;
    assign redirect_pc_o  = redirect_pc_q;

`ifdef DECODE_PERF_CNT_EN
    logic [15:0] stall_cnt_q, flush_cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (in_valid_i & hz & stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
            if (in_valid_i & squash & flush_cnt_q != 16'hFFFF) flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif
endmodule

// File: tb/tb_decode_stage_pl.sv
// tb_decode_stage_pl: directed scenarios for decode_stage_pl with hand-computed expectations.
module tb_decode_stage_pl;
    localparam logic [11:0] C_ALU  = 12'h800;
    localparam logic [11:0] C_LD   = 12'hDA0;
    localparam logic [11:0] C_BEQZ = 12'h188;
    localparam logic [11:0] C_BNEZ = 12'h18A;
    localparam logic [11:0] C_BLTZ = 12'h18C;
    localparam logic [11:0] C_BGEZ = 12'h18E;
    localparam logic [11:0] C_JAL  = 12'h870;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, wb_en = 1'b0, ex_ready = 1'b1;
    logic [15:0] instr = '0, pc = '0, wb_data = '0;
    logic [11:0] ctl = '0;
    logic [2:0]  wb_reg = '0;
    logic        in_ready, out_valid, out_we, out_mem_read, redirect;
    logic [15:0] out_data1, out_data2, out_imm, redirect_pc;
    logic [2:0]  out_wreg;
`ifdef DECODE_PERF_CNT_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    decode_stage_pl dut (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .instr_i(instr), .pc_i(pc), .ctl_i(ctl), .wb_en_i(wb_en), .wb_reg_i(wb_reg),
        .wb_data_i(wb_data), .ex_ready_i(ex_ready), .out_valid_o(out_valid),
        .out_data1_o(out_data1), .out_data2_o(out_data2), .out_imm_o(out_imm),
        .out_wreg_o(out_wreg), .out_we_o(out_we), .out_mem_read_o(out_mem_read),
        .redirect_o(redirect), .redirect_pc_o(redirect_pc)
`ifdef DECODE_PERF_CNT_EN
        , .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] i, input logic [11:0] c, input logic [15:0] p);
        in_valid = 1'b1; instr = i; ctl = c; pc = p;
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) tick();
        checks += 5;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        if (redirect !== 1'b0) begin errors++; $display("FAIL rst_redirect got %b exp 0", redirect); end
        if (redirect_pc !== 16'h0) begin errors++; $display("FAIL rst_redirect_pc got %h exp 0000", redirect_pc); end
        if (out_data1 !== 16'h0) begin errors++; $display("FAIL rst_out_data1 got %h exp 0000", out_data1); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
        @(negedge clk) rst_n = 1'b1;
        tick();
    endtask

    task automatic test_hold;
        issue(16'h0040, C_LD, 16'h0);
        tick();
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_ld_valid got %b exp 1", out_valid); end
        if (out_mem_read !== 1'b1) begin errors++; $display("FAIL hold_ld_memrd got %b exp 1", out_mem_read); end
        ex_ready = 1'b0;
        issue(16'h0054, C_ALU, 16'h0);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready[%0d] got %b exp 0", k, in_ready); end
            tick();
            checks += 2;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d] got %b exp 1", k, out_valid); end
            if (out_wreg !== 3'd2) begin errors++; $display("FAIL hold_wreg[%0d] got %0d exp 2", k, out_wreg); end
        end
`ifdef DECODE_PERF_CNT_EN
        checks++;
        if (stall_cnt !== 16'd3) begin errors++; $display("FAIL stall_cnt got %0d exp 3", stall_cnt); end
`endif
        ex_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_release_ready got %b exp 0", in_ready); end
        tick();
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_bubble got %b exp 0", out_valid); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_after_bubble_ready got %b exp 1", in_ready); end
        tick();
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_issue_valid got %b exp 1", out_valid); end
        if (out_wreg !== 3'd5) begin errors++; $display("FAIL hold_issue_wreg got %0d exp 5", out_wreg); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_wb_forward;
        wb_en = 1'b1; wb_reg = 3'd3; wb_data = 16'h1234;
        issue(16'h0304, C_ALU, 16'h0);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL fwd_in_ready got %b exp 1", in_ready); end
        tick();
        wb_en = 1'b0;
        checks += 4;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL fwd_valid got %b exp 1", out_valid); end
        if (out_data1 !== 16'h1234) begin errors++; $display("FAIL fwd_data1 got %h exp 1234", out_data1); end
        if (out_data2 !== 16'h0000) begin errors++; $display("FAIL fwd_data2 got %h exp 0000", out_data2); end
        if (out_wreg !== 3'd1) begin errors++; $display("FAIL fwd_wreg got %0d exp 1", out_wreg); end
        issue(16'h0068, C_ALU, 16'h0);
        tick();
        checks++;
        if (out_data2 !== 16'h1234) begin errors++; $display("FAIL rf_r3_data2 got %h exp 1234", out_data2); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_load_use;
        issue(16'h0040, C_LD, 16'h0);
        tick();
        checks += 2;
        if (out_wreg !== 3'd2) begin errors++; $display("FAIL lu_ld_wreg got %0d exp 2", out_wreg); end
        if (out_mem_read !== 1'b1) begin errors++; $display("FAIL lu_ld_memrd got %b exp 1", out_mem_read); end
        wb_en = 1'b1; wb_reg = 3'd2; wb_data = 16'hBEEF;
        issue(16'h0054, C_ALU, 16'h0);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL lu_in_ready got %b exp 0", in_ready); end
        tick();
        wb_en = 1'b0;
        #1;
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble got %b exp 0", out_valid); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL lu_ready_after got %b exp 1", in_ready); end
        tick();
        checks += 3;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL lu_issue_valid got %b exp 1", out_valid); end
        if (out_wreg !== 3'd5) begin errors++; $display("FAIL lu_issue_wreg got %0d exp 5", out_wreg); end
        if (out_data2 !== 16'hBEEF) begin errors++; $display("FAIL lu_reread_data2 got %h exp beef", out_data2); end
    endtask

    task automatic test_branch;
        issue(16'h01FC, C_BEQZ, 16'h0010);
        tick();
        checks += 3;
        if (redirect !== 1'b1) begin errors++; $display("FAIL beqz_redirect got %b exp 1", redirect); end
        if (redirect_pc !== 16'h000C) begin errors++; $display("FAIL beqz_target got %h exp 000c", redirect_pc); end
        if (out_imm !== 16'hFFFC) begin errors++; $display("FAIL beqz_imm got %h exp fffc", out_imm); end
        issue(16'h0304, C_ALU, 16'h0012);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL squash_in_ready got %b exp 1", in_ready); end
        tick();
        checks += 3;
        if (redirect !== 1'b0) begin errors++; $display("FAIL squash_redirect_drop got %b exp 0", redirect); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL squash_dropped got %b exp 0", out_valid); end
        if (redirect_pc !== 16'h000C) begin errors++; $display("FAIL squash_pc_hold got %h exp 000c", redirect_pc); end
`ifdef DECODE_PERF_CNT_EN
        checks++;
        if (flush_cnt !== 16'd1) begin errors++; $display("FAIL flush_cnt got %0d exp 1", flush_cnt); end
`endif
        issue(16'h01FC, C_BNEZ, 16'h0010);
        tick();
        checks += 2;
        if (redirect !== 1'b0) begin errors++; $display("FAIL bnez_redirect got %b exp 0", redirect); end
        if (out_valid !== 1'b1) begin errors++; $display("FAIL bnez_valid got %b exp 1", out_valid); end
    endtask

    task automatic test_jump;
        issue(16'h0010, C_ALU, 16'h0);
        tick();
        issue(16'h0400, C_JAL, 16'h0002);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL jump_no_hz got %b exp 1", in_ready); end
        tick();
        checks += 4;
        if (redirect !== 1'b1) begin errors++; $display("FAIL jump_redirect got %b exp 1", redirect); end
        if (redirect_pc !== 16'hFC02) begin errors++; $display("FAIL jump_target got %h exp fc02", redirect_pc); end
        if (out_wreg !== 3'd7) begin errors++; $display("FAIL jump_link_wreg got %0d exp 7", out_wreg); end
        if (out_we !== 1'b1) begin errors++; $display("FAIL jump_link_we got %b exp 1", out_we); end
        in_valid = 1'b0;
        wb_en = 1'b1; wb_reg = 3'd1; wb_data = 16'h8000;
        tick();
        wb_en = 1'b0;
        checks++;
        if (redirect !== 1'b0) begin errors++; $display("FAIL jump_pulse got %b exp 0", redirect); end
        issue(16'h0104, C_BLTZ, 16'h0020);
        tick();
        checks += 2;
        if (redirect !== 1'b1) begin errors++; $display("FAIL bltz_redirect got %b exp 1", redirect); end
        if (redirect_pc !== 16'h0024) begin errors++; $display("FAIL bltz_target got %h exp 0024", redirect_pc); end
        in_valid = 1'b0;
        tick();
        issue(16'h0104, C_BGEZ, 16'h0030);
        tick();
        checks += 3;
        if (redirect !== 1'b0) begin errors++; $display("FAIL bgez_redirect got %b exp 0", redirect); end
        if (out_valid !== 1'b1) begin errors++; $display("FAIL bgez_valid got %b exp 1", out_valid); end
        if (redirect_pc !== 16'h0024) begin errors++; $display("FAIL bgez_pc_hold got %h exp 0024", redirect_pc); end
    endtask

    task automatic test_branch_hazard;
        issue(16'h0004, C_ALU, 16'h0);
        tick();
        issue(16'h01FC, C_BEQZ, 16'h0050);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL brhz_in_ready got %b exp 0", in_ready); end
        tick();
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL brhz_bubble got %b exp 0", out_valid); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL brhz_ready_after got %b exp 1", in_ready); end
        tick();
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL brhz_issue got %b exp 1", out_valid); end
        if (redirect !== 1'b0) begin errors++; $display("FAIL brhz_not_taken got %b exp 0", redirect); end
    endtask

    task automatic test_mid_reset;
        issue(16'h00FC, C_BEQZ, 16'h0040);
        tick();
        checks++;
        if (redirect !== 1'b1) begin errors++; $display("FAIL mrst_pre_redirect got %b exp 1", redirect); end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (redirect !== 1'b0) begin errors++; $display("FAIL mrst_redirect got %b exp 0", redirect); end
        if (redirect_pc !== 16'h0) begin errors++; $display("FAIL mrst_redirect_pc got %h exp 0000", redirect_pc); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL mrst_out_valid got %b exp 0", out_valid); end
        @(negedge clk) rst_n = 1'b1;
        tick();
        checks++;
        if (redirect !== 1'b0) begin errors++; $display("FAIL mrst_no_pending got %b exp 0", redirect); end
        issue(16'h0140, C_ALU, 16'h0);
        tick();
        in_valid = 1'b0;
        checks += 3;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL mrst_issue got %b exp 1", out_valid); end
        if (out_data1 !== 16'h0) begin errors++; $display("FAIL mrst_r1_cleared got %h exp 0000", out_data1); end
        if (out_data2 !== 16'h0) begin errors++; $display("FAIL mrst_r2_cleared got %h exp 0000", out_data2); end
`ifdef DECODE_PERF_CNT_EN
        checks += 2;
        if (stall_cnt !== 16'd0) begin errors++; $display("FAIL mrst_stall_cnt got %0d exp 0", stall_cnt); end
        if (flush_cnt !== 16'd0) begin errors++; $display("FAIL mrst_flush_cnt got %0d exp 0", flush_cnt); end
`endif
    endtask

    initial begin
        test_reset();
        test_hold();
        test_wb_forward();
        test_load_use();
        test_branch();
        test_jump();
        test_branch_hazard();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
